// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package inst_fetch_pkg;

  localparam int InstAddrW = 32;
  localparam int InstW     = 32;

  typedef logic [InstAddrW-1:0] inst_addr_t;
  typedef logic [InstW-1:0]     inst_t;

  localparam inst_t      ZEROWORD    = 32'h0000_0000;
  localparam logic       ChipEnable  = 1'b1;
  localparam logic       ChipDisable = 1'b0;
  localparam inst_addr_t PcStep      = 32'd4;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // Instructions are word aligned; stray low address bits are dropped.
  function automatic inst_addr_t align_pc(input inst_addr_t pc);
    return pc & ~inst_addr_t'(32'h3);
  endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// fetch_buf: 2-entry {pc,inst} FIFO between the ROM and decode.
// Latency: a pushed entry reaches the head on the next cycle when empty.
// Backpressure: push is ignored when full without a same-cycle pop; flush wins over push and pop.
module fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_dat,
  output logic         head_vld,
  output fetch_entry_t head_dat,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign head_vld = (count != 2'd0);
  assign pop_ok   = pop & head_vld;
  assign push_ok  = push & ((count < 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // An empty buffer presents a zero PC and a null instruction word.
  always_comb begin
    head_dat = '{pc: '0, inst: ZEROWORD};
    if (head_vld) begin
      head_dat = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, drives the instruction ROM, buffers words for decode.
// Latency: ROM word visible to decode 1 cycle after fetch; first fetch 2nd cycle after reset.
// Backpressure: fetch stalls (rom_ce_o low, PC held) while the 2-entry buffer is full.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_i,
  input  logic [InstAddrW-1:0] redirect_pc_i,
  output logic                 rom_ce_o,
  output logic [InstAddrW-1:0] rom_addr_o,
  input  logic [InstW-1:0]     rom_inst_i,
  output logic                 id_valid_o,
  input  logic                 id_ready_i,
  output logic [InstAddrW-1:0] id_pc_o,
  output logic [InstW-1:0]     id_inst_o
);

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e       state;
  inst_addr_t   pc;
  logic [1:0]   count;
  logic         pop;
  logic         space;
  logic         push;
  fetch_entry_t head_dat;

  assign pop   = id_valid_o & id_ready_i;
  assign space = (count < 2'd2) | ((count == 2'd2) & pop);

  // Redirect suppresses the fetch so the word at the stale PC is never captured.
  assign rom_ce_o   = ((state == S_RUN) & space & ~redirect_i) ? ChipEnable : ChipDisable;
  assign push       = rom_ce_o;
  assign rom_addr_o = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_RUN;
          if (redirect_i) begin
            pc <= align_pc(redirect_pc_i);
          end
        end
        S_RUN: begin
          if (redirect_i) begin
            pc <= align_pc(redirect_pc_i);
          end else if (push) begin
            pc <= pc + PcStep;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  fetch_buf u_fetch_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_i),
    .push_dat ('{pc: pc, inst: rom_inst_i}),
    .head_vld (id_valid_o),
    .head_dat (head_dat),
    .count    (count)
  );

  assign id_pc_o   = head_dat.pc;
  assign id_inst_o = head_dat.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot, streaming, backpressure, redirects, PC wrap, async reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        w_rom_ce;
  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_inst;
  logic        w_id_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_inst;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // ROM contents: word at byte address n is 32'h1000_0000 + n.
  assign rom_inst   = rom_ce   ? 32'h1000_0000 + rom_addr   : 32'h0;
  assign w_rom_inst = w_rom_ce ? 32'h1000_0000 + w_rom_addr : 32'h0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .rom_ce_o      (rom_ce),
    .rom_addr_o    (rom_addr),
    .rom_inst_i    (rom_inst),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .rom_ce_o      (w_rom_ce),
    .rom_addr_o    (w_rom_addr),
    .rom_inst_i    (w_rom_inst),
    .id_valid_o    (w_id_valid),
    .id_ready_i    (1'b1),
    .id_pc_o       (w_id_pc),
    .id_inst_o     (w_id_inst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_w;

  initial begin
    rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rom_ce",   {31'h0, rom_ce},   32'h0);
    check("rst_rom_addr", rom_addr,          32'h0);
    check("rst_valid",    {31'h0, id_valid}, 32'h0);
    check("rst_id_pc",    id_pc,             32'h0);
    check("rst_id_inst",  id_inst,           32'h0);
    check("rst_w_addr",   w_rom_addr,        32'hFFFF_FFF8);
    check("rst_w_id_pc",  w_id_pc,           32'h0);

    // Cycle 1 after release: still booting.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("boot_rom_ce",  {31'h0, rom_ce},   32'h0);
    check("boot_valid",   {31'h0, id_valid}, 32'h0);

    // Cycle 2: first fetch.
    step(1'b1, 1'b0, 32'h0);
    check("c2_rom_ce",    {31'h0, rom_ce},   32'h1);
    check("c2_rom_addr",  rom_addr,          32'h0);
    check("c2_valid",     {31'h0, id_valid}, 32'h0);

    // Cycle 3: first word at decode.
    step(1'b1, 1'b0, 32'h0);
    check("c3_valid",     {31'h0, id_valid}, 32'h1);
    check("c3_id_pc",     id_pc,             32'h0);
    check("c3_id_inst",   id_inst,           32'h1000_0000);
    check("c3_rom_addr",  rom_addr,          32'h4);
    check("c3_w_id_pc",   w_id_pc,           32'hFFFF_FFF8);
    check("c3_w_id_inst", w_id_inst,         32'h0FFF_FFF8);

    exp_pc = 32'h4;
    exp_w  = 32'hFFFF_FFFC;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0);
      check("stream_id_pc",   id_pc,    exp_pc);
      check("stream_id_inst", id_inst,  32'h1000_0000 + exp_pc);
      check("stream_addr",    rom_addr, exp_pc + 32'h4);
      check("wrap_id_pc",     w_id_pc,  exp_w);
      exp_pc = exp_pc + 32'h4;
      exp_w  = exp_w + 32'h4;
    end

    // Backpressure: one entry already held, one more fetch fills the buffer.
    step(1'b0, 1'b0, 32'h0);
    check("bp0_rom_ce",   {31'h0, rom_ce},   32'h1);
    check("bp0_id_pc",    id_pc,             32'h14);
    check("bp0_addr",     rom_addr,          32'h18);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 32'h0);
      check("bp_rom_ce",  {31'h0, rom_ce},   32'h0);
      check("bp_addr",    rom_addr,          32'h1C);
      check("bp_id_pc",   id_pc,             32'h14);
      check("bp_id_inst", id_inst,           32'h1000_0014);
    end

    // Release: entries drain in order while fetch resumes.
    exp_pc = 32'h14;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0);
      check("rel_valid",  {31'h0, id_valid}, 32'h1);
      check("rel_id_pc",  id_pc,             exp_pc);
      check("rel_rom_ce", {31'h0, rom_ce},   32'h1);
      exp_pc = exp_pc + 32'h4;
    end

    // Redirect with two buffered entries (0x20, 0x24) and an unaligned target.
    step(1'b0, 1'b1, 32'h0000_0103);
    check("rd_rom_ce",    {31'h0, rom_ce},   32'h0);
    check("rd_id_pc",     id_pc,             32'h20);
    step(1'b1, 1'b0, 32'h0);
    check("rd1_valid",    {31'h0, id_valid}, 32'h0);
    check("rd1_addr",     rom_addr,          32'h100);
    check("rd1_rom_ce",   {31'h0, rom_ce},   32'h1);
    step(1'b1, 1'b0, 32'h0);
    check("rd2_valid",    {31'h0, id_valid}, 32'h1);
    check("rd2_id_pc",    id_pc,             32'h100);
    check("rd2_id_inst",  id_inst,           32'h1000_0100);

    // Pop and redirect together: the redirect wins, 0x108 is never emitted.
    step(1'b1, 1'b1, 32'h0000_0200);
    check("rp_id_pc",     id_pc,             32'h104);
    check("rp_rom_ce",    {31'h0, rom_ce},   32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("rp1_valid",    {31'h0, id_valid}, 32'h0);
    check("rp1_addr",     rom_addr,          32'h200);
    step(1'b1, 1'b0, 32'h0);
    check("rp2_id_pc",    id_pc,             32'h200);
    check("rp2_id_inst",  id_inst,           32'h1000_0200);

    // Asynchronous reset pulse mid-stream.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("ar_valid",     {31'h0, id_valid}, 32'h0);
    check("ar_rom_ce",    {31'h0, rom_ce},   32'h0);
    check("ar_addr",      rom_addr,          32'h0);
    check("ar_w_addr",    w_rom_addr,        32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_boot_ce",   {31'h0, rom_ce},   32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("ar_c2_ce",     {31'h0, rom_ce},   32'h1);
    check("ar_c2_addr",   rom_addr,          32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("ar_c3_id_pc",  id_pc,             32'h0);
    check("ar_c3_inst",   id_inst,           32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end of the pipelined MIPS32 core. It owns the program counter and drives the chip-enable and byte address of the combinational instruction ROM. It captures each returned word together with its PC in a 2-entry buffer and presents it to the decode stage over a valid/ready handshake. Branch and exception redirects flush the buffer and restart fetch at the new target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `redirect_i` in 1: redirect request from ID/ctrl.
- `redirect_pc_i` in `InstAddrBus`: redirect target.
- `rom_ce_o` out 1: ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr_o` out `InstAddrBus`: ROM byte address, always equal to the PC register.
- `rom_inst_i` in `InstBus`: ROM data, combinational from `rom_addr_o`/`rom_ce_o`.
- `id_valid_o` out 1: buffer head is valid.
- `id_ready_i` in 1: decode accepts the head this cycle.
- `id_pc_o` out `InstAddrBus`: PC of the head entry.
- `id_inst_o` out `InstBus`: instruction of the head entry; `ZEROWORD` when empty.

## Operation
- **FSM states.**
  - `S_BOOT` is entered on reset. `rom_ce_o`=0, no fetch. Goes to `S_RUN` unconditionally on the next edge.
  - `S_RUN` fetches whenever there is space.
- **Space and push.**
  - `space` = (count<2) | (count==2 & pop). `pop` = `id_valid_o` & `id_ready_i`.
  - In `S_RUN`, `rom_ce_o` = `space` & !`redirect_i`.
  - `push` = `rom_ce_o`. On push, {PC, `rom_inst_i`} is written at the tail and PC <= PC+4.
- **Buffer.** 2-entry circular FIFO of {pc, inst} with a 2-bit count. The head drives `id_pc_o`/`id_inst_o`.
- **Simultaneous push and pop.** Allowed at every count. Count is unchanged and order is preserved.
- **Redirect.** Has priority over push and pop in the same cycle.
  - Count <= 0.
  - PC <= {`redirect_pc_i`[31:2], 2'b00}; low two bits are silently cleared.
  - The word on `rom_inst_i` is discarded.
  - `redirect_i` in `S_BOOT` only loads the PC. The FSM still goes to `S_RUN`.
- **Delay slots.** Not handled here. The issuer asserts `redirect_i` only after the delay-slot instruction has been popped.
- **PC arithmetic.** 32-bit, modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Timing
- **Reset values.**
  - PC = `RESET_PC`, state = `S_BOOT`, count = 0.
  - `rom_ce_o`=0, `rom_addr_o`=`RESET_PC`.
  - `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=`ZEROWORD`.
- **Reset mid-operation** clears the buffer immediately (asynchronous) and re-enters `S_BOOT`.
- **First fetch** happens in the 2nd cycle after `rst` deasserts. The first `id_valid_o` appears in the 3rd cycle.
- **Fetch-to-decode latency** is 1 cycle: a word fetched in cycle N is visible at `id_*` in N+1 if the buffer was empty.
- **Throughput** is 1 instruction/cycle with `id_ready_i` held at 1.
- **Backpressure.** With `id_ready_i`=0 the buffer fills after 2 fetches. `rom_ce_o` then drops and the PC holds.
- **After a redirect in cycle N:** `id_valid_o`=0 in N+1, the target is fetched in N+1 and is valid at `id_*` in N+2.
- **Handshake.**
  - `id_pc_o`/`id_inst_o` are stable while `id_valid_o`=1 and `id_ready_i`=0, unless a redirect occurs.
  - `id_valid_o` does not depend combinationally on `id_ready_i`.

## Structure
- Shared `defines.vh` supplies `InstAddrBus`, `InstBus`, `ZEROWORD`, `ChipEnable`, `ChipDisable`.
- New shared define: `PcStep` (32'd4).
- FSM state encodings are local parameters.
- One natural sub-module, `fetch_buf`: the 2-entry {pc,inst} FIFO with push/pop/flush, count, and head outputs.

## Test plan
- **Reset release, ROM word at address n = 32'h1000_0000 + n, `id_ready_i`=1.**
  - Cycle 1: `rom_ce_o`=0.
  - Cycle 2: `rom_addr_o`=0.
  - Cycle 3: `id_pc_o`=0, `id_inst_o`=32'h1000_0000.
  - Then one instruction per cycle, PC stepping by 4.
- **Backpressure.** Hold `id_ready_i`=0 from steady state.
  - `rom_ce_o` falls after 2 pushes and `rom_addr_o` freezes.
  - Head is unchanged.
  - Release ready: PCs come out in order with no gap or duplicate.
- **Redirect to 32'h0000_0103 with 2 buffered entries.**
  - Next cycle: `id_valid_o`=0.
  - Following cycle: `id_pc_o`=32'h0000_0100.
  - Discarded entries never appear.
- **Simultaneous push, pop and redirect.** The redirect wins, count ends at 0, and no stale instruction is emitted.
- **Wrap-around.** `RESET_PC`=32'hFFFF_FFF8 yields PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Async reset mid-stream.** Pulse `rst` low for half a cycle.
  - `id_valid_o`=0 and `rom_ce_o`=0 immediately.
  - The boot sequence then repeats from `RESET_PC`.
